// File: rtl/sdram_sched_pkg.sv
// sdram_sched_pkg: state encoding, default address width and grant constants for the SDRAM burst scheduler
package sdram_sched_pkg;
  localparam int ADDR_W = 24;
  localparam logic GRANT_WR = 1'b0;
  localparam logic GRANT_RD = 1'b1;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, GUARD} state_t;
endpackage

// File: rtl/sdram_addr_ptr.sv
// sdram_addr_ptr: circular word pointer over [ADDR_BEG, ADDR_END], advanced by one burst length
module sdram_addr_ptr #(
  parameter int ADDR_W = 24,
  parameter logic [ADDR_W-1:0] ADDR_BEG = 24'd0,
  parameter logic [ADDR_W-1:0] ADDR_END = 24'd1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic [9:0]        step,
  output logic [ADDR_W-1:0] ptr
);
  logic [ADDR_W:0] sum;
  assign sum = {1'b0, ptr} + (ADDR_W+1)'(step);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= ADDR_BEG;
    else if (advance) ptr <= (sum > {1'b0, ADDR_END}) ? ADDR_BEG : sum[ADDR_W-1:0];
endmodule

// File: rtl/sdram_burst_sched.sv
// sdram_burst_sched: round-robin write/read burst scheduler between FIFO levels and the SDRAM controller
module sdram_burst_sched #(
  parameter int ADDR_W = sdram_sched_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] ADDR_BEG = 24'd0,
  parameter logic [ADDR_W-1:0] ADDR_END = 24'd1023,
  parameter logic [9:0] RD_FIFO_DEP = 10'd1023,
  parameter logic [3:0] GUARD_CYC = 4'd4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        burst_len,
  input  logic [9:0]        wr_fifo_cnt,
  input  logic [9:0]        rd_fifo_cnt,
  input  logic              rd_enable,
  output logic              sdram_wr_req,
  output logic [ADDR_W-1:0] sdram_wr_addr,
  input  logic              sdram_wr_ack,
  input  logic              sdram_wr_end,
  output logic              sdram_rd_req,
  output logic [ADDR_W-1:0] sdram_rd_addr,
  input  logic              sdram_rd_ack,
  input  logic              sdram_rd_end,
  output logic [ADDR_W:0]   stored_cnt,
  output logic              busy
);
  import sdram_sched_pkg::*;
  localparam int AW1 = ADDR_W + 1;
  localparam int AW2 = ADDR_W + 2;
  localparam logic [ADDR_W:0] REGION = AW1'(ADDR_END) - AW1'(ADDR_BEG) + AW1'(1);
  state_t state, state_nx;
  logic last_grant, last_grant_nx;
  logic [9:0] blen_q, blen_nx;
  logic [3:0] gcnt, gcnt_nx;
  logic [ADDR_W:0] stored_nx;
  logic [ADDR_W+1:0] wr_sum, inc_sum;
  logic wr_ok, rd_ok, grant_wr, grant_rd, wr_adv, rd_adv;
  // Eligibility uses the live burst_len; the granted length is frozen in blen_q
  assign wr_sum = {1'b0, stored_cnt} + AW2'(burst_len);
  assign wr_ok = (burst_len != '0) && (wr_fifo_cnt >= burst_len) && (wr_sum <= {1'b0, REGION});
  assign rd_ok = (burst_len != '0) && rd_enable && (stored_cnt >= AW1'(burst_len))
              && (AW1'(rd_fifo_cnt) + AW1'(burst_len) <= AW1'(RD_FIFO_DEP));
  assign grant_wr = wr_ok && (!rd_ok || last_grant == GRANT_RD);
  assign grant_rd = rd_ok && !grant_wr;
  always_comb begin
    state_nx = state;
    last_grant_nx = last_grant;
    blen_nx = blen_q;
    gcnt_nx = '0;
    wr_adv = 1'b0;
    rd_adv = 1'b0;
    case (state)
      IDLE: begin
        state_nx = grant_wr ? WR_REQ : grant_rd ? RD_REQ : IDLE;
        last_grant_nx = grant_wr ? GRANT_WR : grant_rd ? GRANT_RD : last_grant;
        blen_nx = (grant_wr || grant_rd) ? burst_len : blen_q;
      end
      WR_REQ: begin
        state_nx = !sdram_wr_ack ? WR_REQ : sdram_wr_end ? GUARD : WR_WAIT;
        wr_adv = sdram_wr_ack && sdram_wr_end;
      end
      WR_WAIT: begin
        state_nx = sdram_wr_end ? GUARD : WR_WAIT;
        wr_adv = sdram_wr_end;
      end
      RD_REQ: begin
        state_nx = !sdram_rd_ack ? RD_REQ : sdram_rd_end ? GUARD : RD_WAIT;
        rd_adv = sdram_rd_ack && sdram_rd_end;
      end
      RD_WAIT: begin
        state_nx = sdram_rd_end ? GUARD : RD_WAIT;
        rd_adv = sdram_rd_end;
      end
      GUARD: begin
        state_nx = (gcnt + 4'd1 >= GUARD_CYC) ? IDLE : GUARD;
        gcnt_nx = (gcnt + 4'd1 >= GUARD_CYC) ? '0 : gcnt + 4'd1;
      end
      default: state_nx = IDLE;
    endcase
  end
  // Saturation at both ends only guards against a misbehaving controller
  assign inc_sum = {1'b0, stored_cnt} + AW2'(blen_q);
  assign stored_nx = wr_adv ? ((inc_sum > {1'b0, REGION}) ? REGION : inc_sum[ADDR_W:0])
                   : rd_adv ? ((stored_cnt >= AW1'(blen_q)) ? stored_cnt - AW1'(blen_q) : '0)
                   : stored_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= GRANT_RD;
      blen_q <= '0;
      gcnt <= '0;
      stored_cnt <= '0;
    end else begin
      state <= state_nx;
      last_grant <= last_grant_nx;
      blen_q <= blen_nx;
      gcnt <= gcnt_nx;
      stored_cnt <= stored_nx;
    end
  sdram_addr_ptr #(.ADDR_W(ADDR_W), .ADDR_BEG(ADDR_BEG), .ADDR_END(ADDR_END)) u_wr_ptr (
    .clk(clk), .rst_n(rst_n), .advance(wr_adv), .step(blen_q), .ptr(sdram_wr_addr)
  );
  sdram_addr_ptr #(.ADDR_W(ADDR_W), .ADDR_BEG(ADDR_BEG), .ADDR_END(ADDR_END)) u_rd_ptr (
    .clk(clk), .rst_n(rst_n), .advance(rd_adv), .step(blen_q), .ptr(sdram_rd_addr)
  );
  assign sdram_wr_req = (state == WR_REQ);
  assign sdram_rd_req = (state == RD_REQ);
  assign busy = (state != IDLE);
endmodule

// File: tb/tb_sdram_burst_sched.sv
// tb_sdram_burst_sched: directed scoreboard bench for the SDRAM burst scheduler over a 256-word region
module tb_sdram_burst_sched;
  logic clk = 0, rst_n = 0;
  logic [9:0] burst_len = 10'd64, wr_fifo_cnt = 0, rd_fifo_cnt = 0;
  logic rd_enable = 0, wr_ack = 0, wr_end = 0, rd_ack = 0, rd_end = 0;
  logic wr_req, rd_req, busy;
  logic [23:0] wr_addr, rd_addr;
  logic [24:0] stored_cnt;
  int vectors = 0, miscompares = 0;
  typedef struct packed {logic wr; logic [23:0] addr; logic [24:0] stored;} exp_t;
  exp_t exp_q[$];
  sdram_burst_sched #(.ADDR_END(24'd255)) dut (
    .clk(clk), .rst_n(rst_n), .burst_len(burst_len), .wr_fifo_cnt(wr_fifo_cnt),
    .rd_fifo_cnt(rd_fifo_cnt), .rd_enable(rd_enable),
    .sdram_wr_req(wr_req), .sdram_wr_addr(wr_addr), .sdram_wr_ack(wr_ack), .sdram_wr_end(wr_end),
    .sdram_rd_req(rd_req), .sdram_rd_addr(rd_addr), .sdram_rd_ack(rd_ack), .sdram_rd_end(rd_end),
    .stored_cnt(stored_cnt), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic wait_req();
    int t = 0;
    while (!(wr_req || rd_req) && t < 100) begin @(negedge clk); t++; end
    chk("req_seen", 32'(wr_req || rd_req), 1);
  endtask
  // Serve one burst as the controller would; optionally change burst_len once it is in flight
  task automatic burst(input int ack_dly, input int end_dly, input logic [9:0] new_blen);
    logic wr, held;
    exp_t e;
    wait_req();
    if (!(wr_req || rd_req)) return;
    chk("exp_available", 32'(exp_q.size() != 0), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    wr = wr_req;
    chk("dir", 32'(wr), 32'(e.wr));
    chk("addr", 32'(wr ? wr_addr : rd_addr), 32'(e.addr));
    held = 1;
    repeat (ack_dly) begin
      @(negedge clk);
      held &= (wr ? wr_req : rd_req) && ((wr ? wr_addr : rd_addr) == e.addr);
    end
    chk("req_held", 32'(held), 1);
    if (wr) wr_ack = 1; else rd_ack = 1;
    @(negedge clk);
    wr_ack = 0; rd_ack = 0;
    if (new_blen != 0) burst_len = new_blen;
    chk("req_drop", 32'(wr ? wr_req : rd_req), 0);
    repeat (end_dly) @(negedge clk);
    if (wr) wr_end = 1; else rd_end = 1;
    @(negedge clk);
    wr_end = 0; rd_end = 0;
    chk("stored", 32'(stored_cnt), 32'(e.stored));
  endtask
  task automatic wait_idle();
    int t = 0;
    while (busy && t < 50) begin @(negedge clk); t++; end
    chk("idle", 32'(busy), 0);
  endtask
  task automatic no_req(input string tag, input int n);
    logic seen = 0;
    repeat (n) begin @(negedge clk); seen |= wr_req | rd_req | busy; end
    chk(tag, 32'(seen), 0);
  endtask
  initial begin
    exp_t e;
    int t;
    #2;
    chk("rst_wr_req", 32'(wr_req), 0);
    chk("rst_rd_req", 32'(rd_req), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_stored", 32'(stored_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    // single write burst
    exp_q.push_back('{1'b1, 24'd0, 25'd64});
    wr_fifo_cnt = 64;
    burst(3, 70, 0);
    wr_fifo_cnt = 0;
    chk("wr_addr_after_1", 32'(wr_addr), 64);
    wait_idle();
    // second write, then both eligible: read wins after a write, then write wins after a read
    exp_q.push_back('{1'b1, 24'd64, 25'd128});
    exp_q.push_back('{1'b0, 24'd0, 25'd64});
    exp_q.push_back('{1'b1, 24'd128, 25'd128});
    wr_fifo_cnt = 64;
    burst(2, 5, 0);
    rd_enable = 1;
    burst(1, 10, 0);
    burst(4, 8, 0);
    rd_enable = 0;
    // fill the region, wrapping the write pointer
    exp_q.push_back('{1'b1, 24'd192, 25'd192});
    exp_q.push_back('{1'b1, 24'd0, 25'd256});
    burst(0, 3, 0);
    chk("wr_wrap", 32'(wr_addr), 0);
    burst(1, 3, 0);
    wait_idle();
    no_req("region_full_no_grant", 20);
    exp_q.push_back('{1'b0, 24'd64, 25'd192});
    exp_q.push_back('{1'b1, 24'd64, 25'd256});
    rd_enable = 1;
    burst(2, 4, 0);
    rd_enable = 0;
    burst(2, 4, 0);
    wr_fifo_cnt = 0;
    wait_idle();
    // read FIFO headroom boundary
    rd_fifo_cnt = 990;
    rd_enable = 1;
    no_req("rd_fifo_full_no_grant", 20);
    exp_q.push_back('{1'b0, 24'd128, 25'd192});
    rd_fifo_cnt = 959;
    burst(1, 6, 0);
    rd_enable = 0;
    rd_fifo_cnt = 0;
    wait_idle();
    // zero burst length blocks everything; mid-burst length change is ignored
    burst_len = 0;
    wr_fifo_cnt = 1023;
    rd_enable = 1;
    no_req("blen_zero_idle", 20);
    rd_enable = 0;
    wr_fifo_cnt = 32;
    burst_len = 32;
    exp_q.push_back('{1'b1, 24'd128, 25'd224});
    burst(2, 6, 10'd16);
    wr_fifo_cnt = 0;
    chk("wr_addr_step32", 32'(wr_addr), 160);
    wait_idle();
    // reset in the middle of a read burst
    burst_len = 32;
    rd_enable = 1;
    wait_req();
    e = exp_q.size() != 0 ? exp_q[0] : '0;
    chk("rd_req_before_rst", 32'(rd_req), 1);
    chk("rd_addr_before_rst", 32'(rd_addr), 192);
    rd_ack = 1;
    @(negedge clk);
    rd_ack = 0;
    rd_enable = 0;
    repeat (3) @(negedge clk);
    chk("busy_in_rd_wait", 32'(busy), 1);
    rst_n = 0;
    #1;
    chk("mid_rst_rd_req", 32'(rd_req), 0);
    chk("mid_rst_wr_addr", 32'(wr_addr), 0);
    chk("mid_rst_rd_addr", 32'(rd_addr), 0);
    chk("mid_rst_stored", 32'(stored_cnt), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk); rd_end = 1;
    @(negedge clk); rd_end = 0;
    t = 0;
    chk("stray_end_stored", 32'(stored_cnt), 0);
    chk("stray_end_rd_addr", 32'(rd_addr), 0);
    chk("stray_end_busy", 32'(busy), 0);
    chk("queue_drained", 32'(exp_q.size()), 32'(t));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
